// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 16x16 -> 32-bit radix-2 shift-and-add multiplier.
// A single 32-bit ripple adder (carry_in tied low) is the only arithmetic resource.

module s32_bit_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [32:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[32];
endmodule

module shift_add_multiplier #(
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [15:0] mplier_q, mplier_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] product_q, product_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] add_sum;
   logic        add_cout_unused;

   // carry out is always 0: mcand never exceeds 31 bits and acc stays below 2^32 - mcand
   s32_bit_adder u_adder (
      .a    (acc_q),
      .b    (mcand_q),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout_unused)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d    = 32'h0;
               mcand_d  = {16'h0, a};
               mplier_d = b;
               count_d  = 5'd0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // exhausted multiplier bits finish early, ahead of the iteration count
            if (EARLY_EXIT && (mplier_q == 16'h0)) begin
               product_d = acc_q;
               state_d   = DONE;
            end else begin
               if (mplier_q[0]) acc_d = add_sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               count_d  = count_q + 5'd1;
               if (count_q == 5'd15) begin
                  product_d = mplier_q[0] ? add_sum : acc_q;
                  state_d   = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= 32'h0;
         mcand_q   <= 32'h0;
         mplier_q  <= 16'h0;
         count_q   <= 5'd0;
         product_q <= 32'h0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised and directed checks of shift_add_multiplier, one instance per EARLY_EXIT setting,
// against a plain-arithmetic model of product value and done latency.

module tb_shift_add_multiplier;
   logic        clk = 1'b0;
   logic        rst;
   logic        start0, start1;
   logic [15:0] a0, b0, a1, b1;
   logic        busy0, done0, busy1, done1;
   logic [31:0] product0, product1;
   logic [31:0] prev_prod [2];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   shift_add_multiplier #(.EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .product(product0)
   );

   shift_add_multiplier #(.EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .product(product1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h", tag, got, exp);
   endtask

   // adder carry-out must stay low whenever an iteration is in progress
   always @(negedge clk) begin
      if (!rst && busy0 && !done0) check("cout0", {31'h0, dut0.add_cout_unused}, 32'h0);
      if (!rst && busy1 && !done1) check("cout1", {31'h0, dut1.add_cout_unused}, 32'h0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic st, input logic [15:0] av, input logic [15:0] bv);
      if (sel == 0) begin start0 = st; a0 = av; b0 = bv; end
      else          begin start1 = st; a1 = av; b1 = bv; end
   endtask

   function automatic logic o_busy(input int sel);
      return (sel == 0) ? busy0 : busy1;
   endfunction

   function automatic logic o_done(input int sel);
      return (sel == 0) ? done0 : done1;
   endfunction

   function automatic logic [31:0] o_prod(input int sel);
      return (sel == 0) ? product0 : product1;
   endfunction

   // cycles from the start-sampling edge until done is visible
   function automatic int exp_latency(input int sel, input logic [15:0] bv);
      int msb, runs;
      if (sel == 0) return 17;
      if (bv == 16'h0) return 2;
      msb = 0;
      for (int i = 0; i < 16; i++) if (bv[i]) msb = i;
      runs = (msb + 2 > 16) ? 16 : msb + 2;
      return runs + 1;
   endfunction

   task automatic do_mul(input int sel, input logic [15:0] av, input logic [15:0] bv,
                         input int pulse_at, input int rst_at, input string tag);
      int          n, done_n, ndone;
      logic [31:0] exp_p;
      exp_p  = {16'h0, av} * {16'h0, bv};
      done_n = 0;
      ndone  = 0;
      drive(sel, 1'b1, av, bv);
      step();
      drive(sel, 1'b0, av, bv);
      n = 1;
      check({tag, "_busy1"}, {31'h0, o_busy(sel)}, 32'h1);
      check({tag, "_hold"}, o_prod(sel), prev_prod[sel]);
      while (n < 40) begin
         if (n == pulse_at) drive(sel, 1'b1, 16'h9, 16'h9);
         else if (pulse_at > 0 && n == pulse_at + 1) drive(sel, 1'b0, 16'h5555, 16'h3333);
         if (n == rst_at) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            check({tag, "_rst_busy"}, {31'h0, o_busy(sel)}, 32'h0);
            check({tag, "_rst_done"}, {31'h0, o_done(sel)}, 32'h0);
            check({tag, "_rst_prod"}, o_prod(sel), 32'h0);
            prev_prod[0] = 32'h0;
            prev_prod[1] = 32'h0;
            return;
         end
         if (done_n != 0 && n > done_n) begin
            check({tag, "_idle_busy"}, {31'h0, o_busy(sel)}, 32'h0);
            check({tag, "_idle_done"}, {31'h0, o_done(sel)}, 32'h0);
            break;
         end
         if (o_done(sel)) begin
            ndone++;
            if (done_n == 0) begin
               done_n = n;
               check({tag, "_busy_done"}, {31'h0, o_busy(sel)}, 32'h1);
               check({tag, "_prod"}, o_prod(sel), exp_p);
            end
         end
         step();
         n++;
      end
      if (done_n == 0) check({tag, "_timeout"}, 32'h0, 32'h1);
      else check({tag, "_latency"}, done_n, exp_latency(sel, bv));
      check({tag, "_ndone"}, ndone, 32'h1);
      check({tag, "_prod_after"}, o_prod(sel), exp_p);
      prev_prod[sel] = exp_p;
   endtask

   initial begin
      logic [15:0] ra, rb;
      rst = 1'b1;
      drive(0, 1'b0, 16'h0, 16'h0);
      drive(1, 1'b0, 16'h0, 16'h0);
      prev_prod[0] = 32'h0;
      prev_prod[1] = 32'h0;
      repeat (3) step();
      check("rst_busy0", {31'h0, busy0}, 32'h0);
      check("rst_done0", {31'h0, done0}, 32'h0);
      check("rst_prod0", product0, 32'h0);
      check("rst_busy1", {31'h0, busy1}, 32'h0);
      check("rst_prod1", product1, 32'h0);
      rst = 1'b0;
      step();

      do_mul(0, 16'd3, 16'd5, 0, 0, "m3x5");
      repeat (5) step();
      check("m3x5_held", product0, 32'h0000000F);

      do_mul(0, 16'hFFFF, 16'hFFFF, 0, 0, "max");
      check("max_const", product0, 32'hFFFE0001);
      do_mul(0, 16'h1234, 16'h5678, 0, 0, "m1234");
      check("m1234_const", product0, 32'h06260060);

      do_mul(0, 16'hABCD, 16'h0, 0, 0, "bzero_ee0");
      do_mul(1, 16'hABCD, 16'h0, 0, 0, "bzero_ee1");
      do_mul(1, 16'd7, 16'h1, 0, 0, "b1_ee1");
      check("b1_ee1_const", product1, 32'h7);
      do_mul(1, 16'hFFFF, 16'h8000, 0, 0, "msb_ee1");
      do_mul(1, 16'h00FF, 16'h4000, 0, 0, "b14_ee1");

      do_mul(0, 16'd2, 16'd3, 5, 0, "ignore");
      check("ignore_const", product0, 32'h6);

      do_mul(0, 16'd100, 16'd200, 0, 8, "abort");
      do_mul(0, 16'd10, 16'd10, 0, 0, "after_abort");
      check("after_abort_const", product0, 32'd100);

      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 50 == 0) rb = 16'h0;
         do_mul(0, ra, rb, 0, 0, "rnd0");
      end
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom) >> $urandom_range(0, 15);
         do_mul(1, ra, rb, 0, 0, "rnd1");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
